cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 SHALL have parameter s_offset, default 5, meaning log2 of line bytes (line = 8*2**s_offset = 256 bits).
REQ-002 SHALL have parameter s_beat, default 64, meaning burst beat width in bits; beats per line = line/s_beat (default 4).
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port line_i, input, 256, write line from the L2 pmem_wdata side.
REQ-006 SHALL have port line_o, output, 256, read line to the L2 pmem_rdata side.
REQ-007 SHALL have port address_i, input, 32, line address from L2 pmem_address.
REQ-008 SHALL have ports read_i and write_i, input, 1 each, line request from L2 pmem_read/pmem_write.
REQ-009 SHALL have port resp_o, output, 1, line completion to L2 pmem_resp.
REQ-010 SHALL have ports burst_i and burst_o, input/output, 64 each, beat data from/to burst memory.
REQ-011 SHALL have port address_o, output, 32, line-aligned burst address.
REQ-012 SHALL have ports read_o and write_o, output, 1 each, burst request, and resp_i, input, 1, per-beat acknowledge.

Function
REQ-013 SHALL implement FSM states IDLE, READ, WRITE, DONE.
REQ-014 In IDLE with read_i=1, SHALL latch address_i, clear beat counter, enter READ next cycle; read_i has priority when read_i and write_i are both high.
REQ-015 In IDLE with write_i=1 and read_i=0, SHALL latch address_i and line_i, clear counter, enter WRITE.
REQ-016 address_o SHALL equal {latched address[31:s_offset], s_offset zeros} throughout READ/WRITE.
REQ-017 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE.
REQ-018 In READ, each cycle with resp_i=1 SHALL store burst_i into line bits [cnt*64 +: 64] and increment the 2-bit counter.
REQ-019 In WRITE, burst_o SHALL be line bits [cnt*64 +: 64]; each cycle with resp_i=1 SHALL increment the counter.
REQ-020 resp_i on the last beat (cnt=3) SHALL transition to DONE; the counter SHALL wrap to 0.
REQ-021 In DONE, resp_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Read latency: minimum 6 cycles from read_i sampled to resp_o (1 latch + 4 beats + 1 DONE); resp_i stalls extend it cycle for cycle.
REQ-023 line_o SHALL be valid in the DONE cycle and hold until the next read beat is captured.
REQ-024 resp_i SHALL be ignored in IDLE and DONE; read_i/write_i SHALL be ignored outside IDLE.
REQ-025 burst_o SHALL be 0 outside WRITE.

Reset
REQ-026 rst SHALL force IDLE, counter 0, resp_o/read_o/write_o 0, line_o 0, address_o 0, even mid-burst; no resp_o SHALL follow an aborted transfer.

Structure
REQ-027 FSM state enum and beat-count constants SHALL live in the shared cache package used by l2 cache control.
REQ-028 SHALL be a single module; no sub-module.

Verification
REQ-029 Read: address_i=0x1234_5678, beats 0x11..,0x22..,0x33..,0x44.. with resp_i every cycle -> address_o=0x1234_5660, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o one cycle, 6 cycles.
REQ-030 Write: line_i=256'h0123..cdef, address 0x0000_0040 -> burst_o beats in order low 64 bits first, write_o high 4 resp cycles, then resp_o.
REQ-031 Stalled read: resp_i gaps of 2 cycles between beats -> data captured only on resp_i cycles, resp_o at cycle 12.
REQ-032 read_i and write_i both high -> READ taken, write_o never asserted.
REQ-033 rst during beat 2 of a write -> next cycle IDLE, write_o=0, no resp_o; subsequent read completes normally.
REQ-034 Back-to-back: L2 holds read_i low one cycle after resp_o then issues write -> second transfer starts correctly with counter 0.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache package: FSM state encodings, default geometry and the
// beat-count helper used by the line/burst adaptor and the L2 control logic.
package cacheline_adaptor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int unsigned DEFAULT_S_OFFSET = 5;
  localparam int unsigned DEFAULT_S_BEAT   = 64;

  // Number of burst beats needed to move one cache line.
  function automatic int unsigned beats_per_line(input int unsigned s_offset,
                                                 input int unsigned s_beat);
    return (8 * (2 ** s_offset)) / s_beat;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the L2 line port, the adaptor and burst memory.
//   L2 side    : line_i, address_i, read_i, write_i -> adaptor; line_o, resp_o <- adaptor
//   burst side : burst_i, resp_i -> adaptor; burst_o, address_o, read_o, write_o <- adaptor
// slave  : the adaptor's view
// master : the environment's view (L2 controller plus burst memory)
interface cacheline_adaptor_if
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned s_offset = DEFAULT_S_OFFSET,
  parameter int unsigned s_beat   = DEFAULT_S_BEAT
);
  localparam int unsigned LINE_W = 8 * (2 ** s_offset);

  logic [LINE_W-1:0] line_i;
  logic [LINE_W-1:0] line_o;
  logic [31:0]       address_i;
  logic              read_i;
  logic              write_i;
  logic              resp_o;
  logic [s_beat-1:0] burst_i;
  logic [s_beat-1:0] burst_o;
  logic [31:0]       address_o;
  logic              read_o;
  logic              write_o;
  logic              resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Converts whole-line L2 requests into fixed-length bursts of beats.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - cacheline_adaptor_if.slave (L2 line port and burst port)
// A read collects one beat per resp_i into the read line buffer and pulses
// resp_o for one cycle after the last beat; a write latches the L2 line and
// presents it low beat first. The read buffer is separate from the write
// buffer so line_o holds its value across a following write.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned s_offset = DEFAULT_S_OFFSET,
  parameter int unsigned s_beat   = DEFAULT_S_BEAT
) (
  input logic                 clk,
  input logic                 rst,
  cacheline_adaptor_if.slave  bus
);

  localparam int unsigned LINE_W = 8 * (2 ** s_offset);
  localparam int unsigned BEATS  = beats_per_line(s_offset, s_beat);
  localparam int unsigned CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << s_offset) - 32'd1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       addr;
  logic [LINE_W-1:0] rline;
  logic [LINE_W-1:0] wline;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      addr  <= '0;
      rline <= '0;
      wline <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // read wins when both requests arrive together
          if (bus.read_i) begin
            addr  <= bus.address_i;
            cnt   <= '0;
            state <= ST_READ;
          end else if (bus.write_i) begin
            addr  <= bus.address_i;
            wline <= bus.line_i;
            cnt   <= '0;
            state <= ST_WRITE;
          end
        end
        ST_READ: begin
          if (bus.resp_i) begin
            rline[cnt*s_beat +: s_beat] <= bus.burst_i;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (bus.resp_i) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.line_o    = rline;
  assign bus.resp_o    = (state == ST_DONE);
  assign bus.read_o    = (state == ST_READ);
  assign bus.write_o   = (state == ST_WRITE);
  assign bus.address_o = addr & ALIGN_MASK;
  assign bus.burst_o   = (state == ST_WRITE) ? wline[cnt*s_beat +: s_beat] : '0;

endmodule
